// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a field bundle into a 32-bit word and queues
// it, with its instruction-memory byte address, in a 2-entry output FIFO.
module instr_encoder #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            fmt,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [31:0]           imm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_addr,
   output logic [15:0]           instr_count,
   output logic                  err
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic [DATA_WIDTH-1:0] addr;
   logic [31:0]           enc;
   logic                  legal;
   logic                  accept;
   logic                  push;
   logic                  pop;

   always_comb begin
      enc   = 32'h0;
      legal = 1'b1;
      unique case (fmt)
         FMT_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            // Shift-immediate forms carry funct7 in the upper bits, shamt below it.
            if (opcode == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101))
               enc = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            else
               enc = {imm[11:0], rs1, funct3, rd, opcode};
         end
         FMT_S: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: begin
            enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            if (imm[0]) legal = 1'b0;
         end
         FMT_U: enc = {imm[31:12], rd, opcode};
         FMT_J: begin
            enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            if (imm[0]) legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      if (fmt != FMT_I && opcode[1:0] != 2'b11) legal = 1'b0;
   end

   // rst_n gates in_ready so it reads 0 throughout reset and 1 as soon as it lifts.
   assign in_ready  = rst_n && (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_instr = mem[rd_ptr];
   assign out_addr  = addr;

   assign accept = in_valid && in_ready && !clear;
   assign push   = accept && legal;
   assign pop    = out_valid && out_ready && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0]      <= '0;
         mem[1]      <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         addr        <= BASE_ADDR;
         instr_count <= 16'd0;
         err         <= 1'b0;
      end else if (clear) begin
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         addr        <= BASE_ADDR;
         instr_count <= 16'd0;
         err         <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= enc;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr      <= ~rd_ptr;
            addr        <= addr + DATA_WIDTH'(4);
            instr_count <= instr_count + 16'd1;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
         if (accept && !legal) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, backpressure, clear and async reset,
// then randomized traffic against a queue-based reference model.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic [15:0] instr_count;
   logic        err;

   instr_encoder #(.DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .instr_count(instr_count), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] q_m[$];
   logic [31:0] addr_m;
   int          cnt_m;
   bit          err_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit ref_legal(int f, int op, logic [31:0] im);
      if (f > 5) return 0;
      if ((f == 3 || f == 5) && (im % 2 == 1)) return 0;
      if (f != 1 && (op % 4 != 3)) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] ref_enc(int f, int op, int d, int s1, int s2,
                                           int f3, int f7, logic [31:0] im);
      logic [31:0] w;
      w = 32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15);
      case (f)
         0: w = w | (32'(s2) << 20) | (32'(f7) << 25);
         1: if (op == 'h13 && (f3 == 1 || f3 == 5))
               w = w | ((im & 31) << 20) | (32'(f7) << 25);
            else
               w = w | ((im & 'hFFF) << 20);
         2: w = 32'(op) | ((im & 31) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                | (32'(s2) << 20) | (((im >> 5) & 127) << 25);
         3: w = 32'(op) | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8)
                | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                | (((im >> 5) & 63) << 25) | (((im >> 12) & 1) << 31);
         4: w = 32'(op) | (32'(d) << 7) | (im & 32'hFFFF_F000);
         default: w = 32'(op) | (32'(d) << 7) | (((im >> 12) & 255) << 12)
                | (((im >> 11) & 1) << 20) | (((im >> 1) & 1023) << 21)
                | (((im >> 20) & 1) << 31);
      endcase
      return w;
   endfunction

   task automatic model_reset();
      q_m.delete();
      addr_m = BASE;
      cnt_m  = 0;
      err_m  = 0;
   endtask

   // One clock: predict handshakes from model state, advance model, then compare.
   task automatic tick();
      bit acc, pop;
      acc = in_valid && (q_m.size() < 2);
      pop = out_ready && (q_m.size() > 0);
      @(posedge clk);
      if (clear) model_reset();
      else begin
         if (pop) begin
            void'(q_m.pop_front());
            addr_m = addr_m + 4;
            cnt_m  = (cnt_m + 1) % 65536;
         end
         if (acc) begin
            if (ref_legal(fmt, opcode, imm))
               q_m.push_back(ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
            else
               err_m = 1;
         end
      end
      #1;
      chk("in_ready", 32'(in_ready), 32'(q_m.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q_m.size() > 0));
      chk("out_addr", out_addr, addr_m);
      chk("instr_count", 32'(instr_count), 32'(cnt_m));
      chk("err", 32'(err), 32'(err_m));
      if (q_m.size() > 0) chk("out_instr", out_instr, q_m[0]);
   endtask

   task automatic set_bundle(int f, int op, int d, int s1, int s2, int f3, int f7,
                             logic [31:0] im);
      fmt = 3'(f); opcode = 7'(op); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
      funct3 = 3'(f3); funct7 = 7'(f7); imm = im;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] w, input logic [31:0] a);
      in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
      chk(tag, out_instr, w);
      chk({tag, "_addr"}, out_addr, a);
      tick();
   endtask

   int first_wait;

   initial begin
      rst_n = 0; clear = 0; in_valid = 0; out_ready = 0;
      set_bundle(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", out_addr, BASE);
      rst_n = 1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // directed encodings
      set_bundle(1, 'h13, 1, 0, 0, 0, 0, 5);
      expect_word("addi", 32'h0050_0093, BASE);
      set_bundle(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5000);
      expect_word("lui", 32'h1234_52B7, BASE + 4);
      set_bundle(0, 'h33, 3, 1, 2, 0, 0, 0);
      expect_word("add", 32'h0020_81B3, BASE + 8);
      set_bundle(2, 'h23, 0, 1, 2, 2, 0, 8);
      expect_word("sw", 32'h0020_A423, BASE + 12);
      set_bundle(3, 'h63, 0, 1, 2, 0, 0, 32'hFFFF_FFF8);
      expect_word("beq", 32'hFE20_8CE3, BASE + 16);
      set_bundle(5, 'h6F, 0, 0, 0, 0, 0, 0);
      expect_word("jal", 32'h0000_006F, BASE + 20);
      set_bundle(1, 'h13, 2, 3, 0, 1, 7'h20, 32'hFFFF_FFE3);
      expect_word("slli_form", 32'h4031_9113, BASE + 24);
      set_bundle(3, 'h63, 0, 1, 2, 0, 0, 3);
      in_valid = 1;
      tick();
      in_valid = 0;
      chk("odd_b_err", 32'(err), 1);
      chk("odd_b_count", 32'(instr_count), 7);
      tick();

      // backpressure: three bundles offered, two fit
      out_ready = 0; in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         set_bundle(0, 'h33, i + 1, i, i + 2, 0, 0, 0);
         tick();
      end
      chk("bp_full", 32'(in_ready), 0);
      chk("bp_head", out_instr, ref_enc(0, 'h33, 1, 0, 2, 0, 0, 0));
      tick();
      chk("bp_head_stable", out_instr, ref_enc(0, 'h33, 1, 0, 2, 0, 0, 0));
      out_ready = 1;
      tick();
      chk("bp_ready_after_pop", 32'(in_ready), 1);
      tick();
      in_valid = 0;
      tick(); tick(); tick();
      chk("bp_drained", 32'(out_valid), 0);

      // clear with two queued and a handshake in the same cycle
      out_ready = 0; in_valid = 1;
      set_bundle(7, 'h33, 0, 0, 0, 0, 0, 0);
      tick();
      set_bundle(4, 'h37, 9, 0, 0, 0, 0, 32'hABCD_E000);
      tick(); tick();
      clear = 1;
      tick();
      clear = 0; in_valid = 0;
      chk("clr_empty", 32'(out_valid), 0);
      chk("clr_addr", out_addr, BASE);
      chk("clr_err", 32'(err), 0);
      tick();

      // async reset mid-transfer
      in_valid = 1;
      set_bundle(6, 'h13, 0, 0, 0, 0, 0, 0);
      tick();
      set_bundle(1, 'h13, 4, 4, 0, 0, 0, 12);
      tick(); tick();
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_count", 32'(instr_count), 0);
      chk("arst_addr", out_addr, BASE);
      chk("arst_instr", out_instr, 0);
      model_reset();
      #1 rst_n = 1;
      #1;
      chk("arst_release_ready", 32'(in_ready), 1);

      // first-word latency from an empty FIFO
      out_ready = 0; in_valid = 1;
      set_bundle(4, 'h17, 7, 0, 0, 0, 0, 32'h0000_1000);
      first_wait = 0;
      tick();
      in_valid = 0;
      chk("latency_one", 32'(out_valid), 1);
      out_ready = 1;
      tick();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [31:0] rv;
         r  = $urandom_range(0, 15);
         rv = $urandom;
         set_bundle((r < 14) ? (r % 6) : (r - 8),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                                : int'({rv[6:2], 2'b11}),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 7), $urandom_range(0, 127), $urandom);
         if ($urandom_range(0, 7) != 0) imm[0] = 1'b0;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 59) == 0);
         tick();
      end
      clear = 0; in_valid = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and address width.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: first instruction-memory byte address after reset or clear.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset: asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous flush of FIFO, address and error state.
REQ-006 in_valid  input  1  field bundle valid.
REQ-007 in_ready  output  1  encoder can accept a bundle.
REQ-008 fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 illegal.
REQ-009 opcode  input  7  instr[6:0].
REQ-010 rd, rs1, rs2  input  5 each  register fields.
REQ-011 funct3  input  3 / funct7  input  7  function fields.
REQ-012 imm  input  32  immediate, byte-offset form (B/J include bit 0).
REQ-013 out_valid  output  1  encoded word available.
REQ-014 out_ready  input  1  sink (instruction-memory writer) accepts the word.
REQ-015 out_instr  output  32  encoded RV32I word.
REQ-016 out_addr  output  32  byte address for out_instr.
REQ-017 instr_count  output  16  words delivered since reset/clear.
REQ-018 err  output  1  sticky: an illegal bundle was dropped.

Function
REQ-019 The input is accepted when in_valid && in_ready; the output is delivered when out_valid && out_ready.
REQ-020 Each accepted legal bundle SHALL be encoded combinationally and pushed into a 2-entry FIFO of registered words.
REQ-021 Latency: accept in cycle N -> out_valid=1 in cycle N+1 if the FIFO was empty; no combinational in->out path.
REQ-022 in_ready SHALL be !full, registered-state only, and independent of out_ready (no bypass when full).
REQ-023 R encoding: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-024 I encoding: {imm[11:0], rs1, funct3, rd, opcode}. Exception: when opcode=0010011 and funct3 is 001 or 101, use {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-025 S encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-026 B encoding: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-027 U encoding: {imm[31:12], rd, opcode}.
REQ-028 J encoding: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-029 Illegal bundles SHALL be accepted (handshake completes) but not enqueued, and SHALL set err. Illegal means any of:
- fmt 6 or 7;
- B or J with imm[0]=1;
- R/S/B/U/J with opcode[1:0] != 2'b11.
REQ-030 out_instr and out_addr SHALL reflect the FIFO head. They SHALL be stable while out_valid && !out_ready.
REQ-031 On each delivery:
- the address pointer SHALL advance by 4, wrapping modulo 2^32;
- instr_count SHALL increment, wrapping 16'hFFFF -> 0.
REQ-032 Simultaneous push and pop SHALL leave the occupancy unchanged, with correct ordering. With 1 entry, both may occur in the same cycle.
REQ-033 When clear=1 for a cycle:
- the FIFO empties;
- out_addr becomes BASE_ADDR;
- instr_count and err become 0;
- a handshake in the same cycle SHALL be discarded, with clear taking priority.
REQ-034 err SHALL remain 1 until reset or clear.

Reset
REQ-035 While rst_n=0:
- out_valid=0, in_ready=0, err=0, instr_count=0;
- out_addr=BASE_ADDR;
- FIFO empty, and out_instr=32'h0000_0000.
REQ-036 In the first cycle after rst_n deasserts, in_ready=1.
REQ-037 Reset asserted mid-transfer SHALL drop all FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-038 I/U: fmt=1, op=0010011, f3=000, rd=1, rs1=0, imm=5 -> 0x00500093 at addr 0. Then fmt=4, op=0110111, rd=5, imm=0x12345000 -> 0x123452B7 at addr 4.
REQ-039 R/S: fmt=0 add x3,x1,x2 -> 0x002081B3. Then fmt=2 sw x2,8(x1) -> 0x0020A423.
REQ-040 B/J: beq x1,x2,imm=-8 -> 0xFE208CE3. Then fmt=5, rd=0, imm=0, op=1101111 -> 0x0000006F. Then B with imm=3 -> dropped, err=1, instr_count unchanged.
REQ-041 Backpressure: out_ready=0 with 3 bundles offered -> 2 accepted, in_ready=0, head stable. Raise out_ready -> words delivered in order, third bundle accepted in the pop cycle +1.
REQ-042 Clear/reset: 2 entries queued, pulse clear with in_valid=1 -> FIFO empty, out_addr=BASE_ADDR, count=0, input dropped. Assert rst_n=0 asynchronously -> outputs reach REQ-035 values before the next edge.
